ysyx_22041412_dmem_resp: RTL

Data-memory responder serving the MEM-stage load/store request interface (en/wen/func3/addr/wdata in; rdata/stall/readyo out; readyi in).
- Holds a parameterised word-addressed RAM.
- Performs RV64 sized accesses with byte-lane merge on stores and sign/zero extension on loads.
- Models a configurable access latency through a busy/ready handshake, so the pipeline's stall logic runs against a real multi-cycle memory.

---
 rtl/ysyx_22041412_dmem_resp_pkg.sv | 18 +
 rtl/ysyx_22041412_lsu_align.sv | 56 +++++
 rtl/ysyx_22041412_dmem_resp.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22041412_dmem_resp_pkg.sv
// Shared encodings for the data-memory responder: func3 access sizes and FSM states.
package ysyx_22041412_dmem_resp_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/ysyx_22041412_lsu_align.sv
// Byte-lane alignment for one 64-bit RAM word: store merge, load extension, misalignment.
module ysyx_22041412_lsu_align
  import ysyx_22041412_dmem_resp_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [2:0]  lane,
  input  logic [63:0] wdata,
  input  logic [63:0] word,
  output logic [7:0]  mask,
  output logic [63:0] merged,
  output logic [63:0] ld_data,
  output logic        misaligned
);

  logic [5:0]  sh;
  logic [7:0]  base_mask;
  logic [63:0] wshift;
  logic [63:0] raw;

  always_comb begin
    sh = {lane, 3'b000};
    case (func3[1:0])
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
    mask   = base_mask << lane;
    wshift = wdata << sh;
    merged = word;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) merged[8*i +: 8] = wshift[8*i +: 8];
    end

    raw = word >> sh;
    case (func3)
      F3_B:    ld_data = {{56{raw[7]}}, raw[7:0]};
      F3_H:    ld_data = {{48{raw[15]}}, raw[15:0]};
      F3_W:    ld_data = {{32{raw[31]}}, raw[31:0]};
      F3_BU:   ld_data = {56'd0, raw[7:0]};
      F3_HU:   ld_data = {48'd0, raw[15:0]};
      F3_WU:   ld_data = {32'd0, raw[31:0]};
      default: ld_data = raw;
    endcase

    // func3=111 has no legal size, so it is rejected like a misaligned access
    case (func3)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = lane[0];
      F3_W, F3_WU: misaligned = (lane[1:0] != 2'd0);
      F3_D:        misaligned = (lane != 3'd0);
      default:     misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_22041412_dmem_resp.sv
// MEM-stage data memory: word RAM behind a fixed-latency busy/ready handshake.
// Handshake: stall=1 means the MEM stage holds its request; a response is
// transferred on a rising edge where readyo=1 and readyi=1.
module ysyx_22041412_dmem_resp
  import ysyx_22041412_dmem_resp_pkg::*;
#(
  parameter logic [63:0] BASE    = 64'h0000000080000000,
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        wen,
  input  logic [2:0]  func3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        stall,
  output logic        readyo,
  input  logic        readyi,
  output logic        err,
  output logic [1:0]  dbg_state
);

  localparam int          AW   = $clog2(DEPTH);
  localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

  dmem_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_wen_q, req_wen_d;
  logic [2:0]    req_func3_q, req_func3_d;
  logic [63:0]   req_addr_q, req_addr_d;
  logic [63:0]   req_wdata_q, req_wdata_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [63:0]   mem [DEPTH];
  logic [63:0]   offset;
  logic [AW-1:0] word_idx;
  logic          out_of_range;
  logic          bad;
  logic          mem_we;
  logic [7:0]    byte_mask;
  logic [63:0]   merged_word;
  logic [63:0]   ld_data;
  logic          misaligned;

  // Unsigned subtraction wraps addresses below BASE into the out-of-range half
  assign offset       = req_addr_q - BASE;
  assign word_idx     = offset[3 +: AW];
  assign out_of_range = (offset >= SPAN);
  assign bad          = out_of_range | misaligned;

  ysyx_22041412_lsu_align u_align (
    .func3      (req_func3_q),
    .lane       (req_addr_q[2:0]),
    .wdata      (req_wdata_q),
    .word       (mem[word_idx]),
    .mask       (byte_mask),
    .merged     (merged_word),
    .ld_data    (ld_data),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_wen_d   = req_wen_q;
    req_func3_d = req_func3_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    stall       = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = en;
        if (en) begin
          req_wen_d   = wen;
          req_func3_d = func3;
          req_addr_d  = addr;
          req_wdata_d = wdata;
          cnt_d       = CW'(LATENCY - 1);
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          err_d   = bad;
          mem_we  = req_wen_q & ~bad;
          rdata_d = (req_wen_q | bad) ? 64'd0 : ld_data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        stall = ~readyi;
        if (readyi) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_wen_q   <= 1'b0;
      req_func3_q <= 3'd0;
      req_addr_q  <= 64'd0;
      req_wdata_q <= 64'd0;
      rdata_q     <= 64'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_wen_q   <= req_wen_d;
      req_func3_q <= req_func3_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // RAM is not reset; a reset during ACCESS forces IDLE before the write edge
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= merged_word;
  end

  assign rdata     = rdata_q;
  assign readyo    = (state_q == ST_RESP);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
